// File: rtl/pdm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pdm_sample_feeder
// Purpose  : Buffers signed audio samples from a valid/ready stream in a
//            small FIFO and, on each programmable sample-rate tick, pops one
//            and presents it as unsigned offset-binary to the PDM modulator.
// Options  : `define PDM_FEED_VOLUME_EN adds a 4-bit `vol` port that
//            arithmetic-shifts each popped sample right before conversion.
// Revision : 1.0 - initial release
// ============================================================================
module pdm_sample_feeder #(
    parameter int NBITS = 16,
    parameter int DEPTH = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [DIV_W-1:0]         divisor,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [NBITS-1:0]         s_data,
    output logic [NBITS-1:0]         sample,
    output logic                     sample_strobe,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    input  logic                     clear_underrun
`ifdef PDM_FEED_VOLUME_EN
    ,
    input  logic [3:0]               vol
`endif
);

    localparam int               PW       = $clog2(DEPTH);
    localparam int               LW       = PW + 1;
    localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
    localparam logic [NBITS-1:0] MIDSCALE = {1'b1, {(NBITS-1){1'b0}}};

    logic [NBITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [NBITS-1:0] sample_q, sample_d;
    logic             strobe_q, strobe_d;
    logic             underrun_q, underrun_d;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_tick;
    logic                    w_empty;
    logic                    w_full;
    logic signed [NBITS-1:0] w_head;
    logic [NBITS-1:0]        w_scaled;

    // Flow control depends on occupancy only, so a pop never opens s_ready
    // within the same cycle.
    assign w_full        = (count_q == FULL_LVL);
    assign w_empty       = (count_q == '0);
    assign s_ready       = ~w_full;
    assign w_push        = s_valid & ~w_full;
    assign w_tick        = enable & (cnt_q == '0);
    // Empty is judged on the registered level: a word pushed this edge is
    // never popped on the same edge.
    assign w_pop         = w_tick & ~w_empty;
    assign w_head        = mem_q[rd_ptr_q];
    assign sample        = sample_q;
    assign sample_strobe = strobe_q;
    assign level         = count_q;
    assign underrun      = underrun_q;

`ifdef PDM_FEED_VOLUME_EN
    assign w_scaled = w_head >>> vol;
`else
    assign w_scaled = w_head;
`endif

    // Next-state logic for pointers, occupancy, tick counter and outputs.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        cnt_d      = cnt_q;
        sample_d   = sample_q;
        strobe_d   = 1'b0;
        underrun_d = underrun_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        if (!enable) begin
            cnt_d    = '0;
            sample_d = MIDSCALE;
        end else if (cnt_q == '0) begin
            cnt_d = divisor;
        end else begin
            cnt_d = cnt_q - DIV_W'(1);
        end

        if (w_pop) begin
            // Offset-binary conversion is a plain MSB flip.
            sample_d = w_scaled ^ MIDSCALE;
            strobe_d = 1'b1;
        end

        // A fresh underrun event outranks a clear request.
        if (w_tick && w_empty) begin
            underrun_d = 1'b1;
        end else if (clear_underrun) begin
            underrun_d = 1'b0;
        end
    end

    // Control state register; reset flushes the FIFO by zeroing pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cnt_q      <= '0;
            sample_q   <= MIDSCALE;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cnt_q      <= cnt_d;
            sample_q   <= sample_d;
            strobe_q   <= strobe_d;
            underrun_q <= underrun_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pdm_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pdm_sample_feeder
// Purpose  : Directed bench for pdm_sample_feeder with a strobe-driven
//            scoreboard for emitted samples and direct status checks.
// Options  : honours PDM_FEED_VOLUME_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pdm_sample_feeder;

    localparam int NBITS = 16;
    localparam int DEPTH = 8;
    localparam int DIV_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [DIV_W-1:0]  divisor;
    logic              s_valid;
    logic              s_ready;
    logic [NBITS-1:0]  s_data;
    logic [NBITS-1:0]  sample;
    logic              sample_strobe;
    logic [3:0]        level;
    logic              underrun;
    logic              clear_underrun;
`ifdef PDM_FEED_VOLUME_EN
    logic [3:0]        vol;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [NBITS-1:0] exp_q[$];
    int               strobe_cyc[$];

    pdm_sample_feeder #(.NBITS(NBITS), .DEPTH(DEPTH), .DIV_W(DIV_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .divisor        (divisor),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .sample         (sample),
        .sample_strobe  (sample_strobe),
        .level          (level),
        .underrun       (underrun),
        .clear_underrun (clear_underrun)
`ifdef PDM_FEED_VOLUME_EN
        ,
        .vol            (vol)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected sample.
    always @(negedge clk) begin
        if (sample_strobe === 1'b1) begin
            tests++;
            strobe_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL strobe_unexpected: got sample 0x%04h, no sample expected", sample);
            end else begin
                logic [NBITS-1:0] e;
                e = exp_q.pop_front();
                if (sample !== e) begin
                    fails++;
                    $display("FAIL strobe_sample: got 0x%04h expected 0x%04h", sample, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [NBITS-1:0] d);
        s_valid = 1'b1;
        s_data  = d;
        step(1);
        s_valid = 1'b0;
    endtask

    logic [NBITS-1:0] w [9];
    logic [NBITS-1:0] p [6];

    initial begin
        rst = 1'b1; enable = 1'b0; divisor = '0; s_valid = 1'b0;
        s_data = '0; clear_underrun = 1'b0;
`ifdef PDM_FEED_VOLUME_EN
        vol = 4'd0;
`endif
        step(3);
        rst = 1'b0;

        // Reset state
        check("rst_sample",   32'(sample), 32'h8000);
        check("rst_strobe",   32'(sample_strobe), 0);
        check("rst_s_ready",  32'(s_ready), 1);
        check("rst_level",    32'(level), 0);
        check("rst_underrun", 32'(underrun), 0);

        // Three words buffered while idle, then ticks every 4 cycles
        push(16'h0000); push(16'h7FFF); push(16'h8000);
        check("idle_level3", 32'(level), 3);
        exp_q.push_back(16'h8000); exp_q.push_back(16'hFFFF); exp_q.push_back(16'h0000);
        strobe_cyc.delete();
        divisor = 16'd3; enable = 1'b1;
        step(12);
        check("underrun_before_4th", 32'(underrun), 0);
        step(1);
        check("underrun_4th_tick", 32'(underrun), 1);
        check("sample_hold",       32'(sample), 32'h0000);
        check("strobe_count",      32'(strobe_cyc.size()), 3);
        if (strobe_cyc.size() == 3) begin
            check("strobe_gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 4);
            check("strobe_gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 4);
        end

        // Idle output returns to midscale; fill to full with s_valid held
        enable = 1'b0;
        step(1);
        check("idle_midscale", 32'(sample), 32'h8000);
        for (int i = 0; i < 9; i++) w[i] = NBITS'(16'h1000 * i + i);
        s_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            s_data = w[i];
            if (i < 8) step(1);
        end
        check("full_level",   32'(level), 8);
        check("full_s_ready", 32'(s_ready), 0);
        step(2);
        check("full_hold_level", 32'(level), 8);
        for (int i = 0; i < 9; i++) exp_q.push_back(w[i] ^ 16'h8000);
        divisor = 16'd7; enable = 1'b1;
        step(1);
        check("pop_s_ready", 32'(s_ready), 1);
        check("pop_level",   32'(level), 7);
        step(1);
        s_valid = 1'b0;
        check("ninth_level", 32'(level), 8);
        step(63);
        check("drain_level", 32'(level), 0);

        // Clear colliding with an empty tick: set wins
        enable = 1'b0;
        step(1);
        enable = 1'b1; divisor = 16'd3; clear_underrun = 1'b1;
        step(1);
        check("clear_vs_tick", 32'(underrun), 1);
        step(1);
        check("clear_no_tick", 32'(underrun), 0);
        clear_underrun = 1'b0;
        step(4);
        check("underrun_again", 32'(underrun), 1);

        // Reset mid-stream with five words buffered
        enable = 1'b0;
        step(1);
        for (int i = 0; i < 6; i++) p[i] = NBITS'(16'h0101 * (i + 3));
        for (int i = 0; i < 6; i++) push(p[i]);
        check("pre_rst_level6", 32'(level), 6);
        exp_q.push_back(p[0] ^ 16'h8000);
        divisor = 16'd100; enable = 1'b1;
        step(1);
        check("pre_rst_level5", 32'(level), 5);
        check("pre_rst_sample", 32'(sample), 32'(p[0] ^ 16'h8000));
        rst = 1'b1;
        step(1);
        rst = 1'b0; divisor = 16'd0;
        check("mid_rst_level",    32'(level), 0);
        check("mid_rst_sample",   32'(sample), 32'h8000);
        check("mid_rst_strobe",   32'(sample_strobe), 0);
        check("mid_rst_underrun", 32'(underrun), 0);
        check("mid_rst_s_ready",  32'(s_ready), 1);
        step(4);
        check("post_rst_underrun", 32'(underrun), 1);
        check("post_rst_sample",   32'(sample), 32'h8000);

`ifdef PDM_FEED_VOLUME_EN
        // Volume shift applied at each tick
        enable = 1'b0;
        step(1);
        push(16'h4000); push(16'h8000); push(16'h1234);
        exp_q.push_back(16'h9000); exp_q.push_back(16'h6000); exp_q.push_back(16'h9234);
        vol = 4'd2; divisor = 16'd3; enable = 1'b1;
        step(5);
        vol = 4'd0;
        step(4);
        check("vol_sample_last", 32'(sample), 32'h9234);
`endif

        step(2);
        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pdm_sample_feeder.md
Name: pdm_sample_feeder

Overview:
- Upstream stage of the pulse-density modulator.
- Accepts signed two's-complement audio samples over a valid/ready stream and buffers them in a small FIFO.
- Pops one sample per programmable sample-rate tick and converts it to unsigned offset-binary.
- Holds the result on `sample`, which drives the modulator's `din` directly.

Parameters:
- NBITS, 16: sample width; must match the modulator's NBITS.
- DEPTH, 8: FIFO depth in entries; power of 2, ≥ 2.
- DIV_W, 16: width of the sample-rate divisor.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run the sample-rate tick; low = idle output
- divisor  in  DIV_W  tick period minus 1, in clk cycles
- s_valid  in  1  input sample valid
- s_ready  out  1  FIFO can accept; equals !full, combinational from occupancy only
- s_data  in  NBITS  signed input sample
- sample  out  NBITS  unsigned offset-binary sample to the modulator's din; registered
- sample_strobe  out  1  one-cycle pulse when `sample` is updated from the FIFO
- level  out  $clog2(DEPTH)+1  current FIFO occupancy
- underrun  out  1  sticky; set when a tick finds the FIFO empty
- clear_underrun  in  1  clears `underrun`

Behaviour:
- Reset values:
  - sample = 2^(NBITS-1) (midscale, 0x8000 at NBITS=16)
  - sample_strobe = 0, underrun = 0, level = 0
  - FIFO pointers = 0, tick counter = 0
  - s_ready = 1 in the first cycle after reset
  - Reset asserted mid-stream flushes the FIFO and discards buffered data.
- Push: occurs when s_valid & s_ready at a clock edge; s_data is written at the write pointer.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
- Tick counter, when enable = 1:
  - counter == 0: a tick occurs and counter reloads from divisor.
  - Otherwise counter decrements by 1.
  - Tick period is divisor+1 cycles; divisor = 0 gives a tick every cycle.
  - divisor is sampled only at reload.
- Tick with FIFO non-empty:
  - Pop the head entry.
  - sample <= head XOR (1 << (NBITS-1)), i.e. MSB inverted.
  - sample_strobe = 1 for the following cycle.
- Tick with FIFO empty:
  - sample holds its previous value; no strobe.
  - underrun <= 1.
- Simultaneous push and pop:
  - Level is unchanged.
  - If the FIFO was empty, there is no fall-through: the pop sees empty and underrun is set; the pushed word stays in the FIFO.
- Push when full cannot occur, because s_ready = 0.
- Pop in the same cycle as full: s_ready stays 0 that cycle and rises the next cycle.
- Latency: a word pushed at edge N is poppable at the earliest tick at edge N+1 or later.
- enable = 0:
  - counter <= 0 and sample <= midscale on the next edge; no pops, no strobes.
  - FIFO still accepts pushes.
  - On the first enabled cycle the tick fires immediately (counter == 0).
- clear_underrun: clears underrun. If a new underrun event occurs in the same cycle, set wins.
- Arithmetic: no saturation is needed in the base block; the offset conversion is exact.

Optional Feature:
- Macro: PDM_FEED_VOLUME_EN.
- Defined:
  - Adds input port `vol` (4 bits).
  - The popped signed sample is arithmetic-shifted right by vol (0–15) before offset conversion; the sign is preserved.
  - vol is sampled at the tick.
- Undefined:
  - `vol` is absent.
  - The sample passes unscaled.

Test Plan:
- Reset with NBITS=16, DEPTH=8 -> sample=0x8000, sample_strobe=0, s_ready=1, level=0, underrun=0.
- Push 0x0000, 0x7FFF, 0x8000 with enable=0, then enable=1, divisor=3 -> strobes 4 cycles apart carrying sample 0x8000, 0xFFFF, 0x0000; the fourth tick sets underrun=1 and sample holds 0x0000.
- enable=0, push 9 words with s_valid held -> s_ready=0 after the 8th, level=8, 9th word held; after enable=1 and the first pop, s_ready=1 the next cycle and the 9th word is accepted.
- Underrun set, then clear_underrun=1 on a cycle where an empty tick also occurs -> underrun remains 1; clear_underrun on a non-tick cycle -> underrun=0.
- rst pulsed with level=5 while enabled -> next cycle level=0, sample=0x8000, strobe=0; after 4 empty ticks at divisor=0, underrun=1.
- PDM_FEED_VOLUME_EN, vol=2:
  - push 0x4000 -> sample=0x9000
  - push 0x8000 -> sample=0x6000
  - vol=0, push 0x1234 -> sample=0x9234
